pet_bus_mapper: RTL and testbench

//  Parametrised CPU address decoder / memory mapper for the PET family, successor to the fixed 32K decoder.

---
 rtl/pet_map_pkg.sv | 38 +++
 rtl/pet_map_decode.sv | 68 ++++++
 rtl/pet_bus_mapper.sv | 176 +++++++++++++++++
 tb/tb_pet_bus_mapper.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_map_pkg.sv
// Shared types and constants for the PET bus mapper: bus regions, DMA states, ctrl bit layout.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pet_map_pkg;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_EXP,
    RGN_VRAM,
    RGN_ROM,
    RGN_IO,
    RGN_NONE
  } region_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_ACC,
    DMA_ACK
  } dma_state_t;

  // Expansion control register bit positions
  localparam int CTRL_EXP_EN   = 7;
  localparam int CTRL_IO_PEEK  = 6;
  localparam int CTRL_SCR_PEEK = 5;
  localparam int CTRL_WP_HI    = 3;
  localparam int CTRL_WP_LO    = 2;
  localparam int CTRL_BANK_HI  = 1;
  localparam int CTRL_BANK_LO  = 0;

  // Expansion RAM sits directly above the 32K base RAM, in four 16K banks
  localparam logic [16:0] EXP_BASE = 17'h08000;

  // Physical address of a byte inside expansion bank 'bank' (0..3)
  function automatic logic [16:0] exp_phys(input logic [1:0] bank, input logic [13:0] off);
    return EXP_BASE + {1'b0, bank, off};
  endfunction

endpackage

// File: rtl/pet_map_decode.sv
// Combinational CPU address decode: region, physical RAM/ROM/VRAM address, write permission.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result is consumed in the same cycle as cpu_ce.
module pet_map_decode
  import pet_map_pkg::*;
#(
  parameter int RAM_AW  = 17,
  parameter int VRAM_AW = 10,
  parameter int ROM_AW  = 15
) (
  input  logic [15:0]        addr,
  input  logic [7:0]         ctrl,
  output region_t            rgn,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               wr_ok
);

  logic        io_win;
  logic        scr_win;
  logic        hi_win;
  logic [1:0]  bank;
  logic [16:0] phys;
  logic        unused_ctrl;

  // Bit 4 of the control register has no mapping function
  assign unused_ctrl = ctrl[4];

  assign io_win  = (addr[15:11] == 5'b11101);   // $E800-$EFFF
  assign scr_win = (addr[15:12] == 4'h8);       // $8000-$8FFF
  assign hi_win  = addr[14];                    // $C000-$FFFF half of the upper 32K

  // Bank number: low bit selects the half, high bit comes from the half's ctrl select
  assign bank = {(hi_win ? ctrl[CTRL_BANK_HI] : ctrl[CTRL_BANK_LO]), hi_win};

  // Region and physical address selection
  always_comb begin
    rgn   = RGN_NONE;
    phys  = {2'b00, addr[14:0]};
    wr_ok = 1'b0;
    if (!addr[15]) begin
      rgn   = RGN_RAM;
      wr_ok = 1'b1;
    end else if (ctrl[CTRL_EXP_EN]) begin
      if (ctrl[CTRL_SCR_PEEK] && scr_win) begin
        rgn = RGN_VRAM;
      end else if (ctrl[CTRL_IO_PEEK] && io_win) begin
        rgn = RGN_IO;
      end else begin
        rgn   = RGN_EXP;
        phys  = exp_phys(bank, addr[13:0]);
        wr_ok = !(hi_win ? ctrl[CTRL_WP_HI] : ctrl[CTRL_WP_LO]);
      end
    end else if (scr_win) begin
      rgn = RGN_VRAM;
    end else if (io_win) begin
      rgn = RGN_IO;
    end else begin
      rgn = RGN_ROM;
    end
  end

  assign ram_addr  = phys[RAM_AW-1:0];
  assign rom_addr  = addr[ROM_AW-1:0];
  assign vram_addr = addr[VRAM_AW-1:0];

endmodule

// File: rtl/pet_bus_mapper.sv
// PET CPU bus mapper: decodes 6502 cycles to RAM/ROM/VRAM/IO, 8096 banking register, DMA port.
// Latency: strobes in the cpu_ce cycle, cpu_dout one clk later; DMA ack two clk after grant.
// Backpressure: cpu_ce always owns the memory ports; DMA waits in ACC until a CPU-free clk.
module pet_bus_mapper
  import pet_map_pkg::*;
#(
  parameter int          RAM_AW    = 17,
  parameter int          VRAM_AW   = 10,
  parameter int          ROM_AW    = 15,
  parameter int          MAP_8096  = 1,
  parameter logic [15:0] CTRL_ADDR = 16'hFFF0,
  parameter logic [7:0]  UNMAP_VAL = 8'h55
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_ce,
  input  logic [15:0]        cpu_addr,
  input  logic               cpu_we,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic               ram_we,
  output logic [7:0]         ram_wdata,
  input  logic [7:0]         ram_rdata,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic               rom_we,
  input  logic [7:0]         rom_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  input  logic [7:0]         vram_rdata,
  output logic               io_cs,
  input  logic [7:0]         io_rdata,
  input  logic               dma_req,
  input  logic               dma_space,
  input  logic [RAM_AW-1:0]  dma_addr,
  input  logic               dma_we,
  input  logic [7:0]         dma_din,
  output logic [7:0]         dma_dout,
  output logic               dma_ack,
  output logic [7:0]         ctrl_q
);

  region_t           rgn;
  region_t           rgn_q;
  logic [RAM_AW-1:0] cpu_ram_addr;
  logic [ROM_AW-1:0] cpu_rom_addr;
  logic              wr_ok;
  logic              ctrl_hit;
  logic              rd_pend;
  logic [7:0]        ctrl;
  logic [7:0]        ctrl_din;
  logic [7:0]        io_q;
  logic [7:0]        rd_data;
  dma_state_t        state;
  dma_state_t        state_nxt;

  pet_map_decode #(
    .RAM_AW  (RAM_AW),
    .VRAM_AW (VRAM_AW),
    .ROM_AW  (ROM_AW)
  ) u_decode (
    .addr      (cpu_addr),
    .ctrl      (ctrl),
    .rgn       (rgn),
    .ram_addr  (cpu_ram_addr),
    .rom_addr  (cpu_rom_addr),
    .vram_addr (vram_addr),
    .wr_ok     (wr_ok)
  );

  // The control register write is swallowed here: it never reaches RAM or ROM
  assign ctrl_hit = (MAP_8096 != 0) && cpu_ce && cpu_we && (cpu_addr == CTRL_ADDR);
  assign ctrl_q   = ctrl;

  // Without expansion RAM fitted the enable bit cannot be set
  always_comb begin
    ctrl_din = cpu_din;
    if (RAM_AW < 17) ctrl_din[CTRL_EXP_EN] = 1'b0;
  end

  // Expansion control register, loaded at the cpu_ce edge regardless of current mapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= 8'h00;
    end else if (ctrl_hit) begin
      ctrl <= ctrl_din;
    end
  end

  // Latch the region of a CPU read; io_rdata is only valid in the ce clk so capture it too
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgn_q   <= RGN_NONE;
      rd_pend <= 1'b0;
      io_q    <= 8'h00;
    end else begin
      rd_pend <= cpu_ce && !cpu_we;
      if (cpu_ce) begin
        rgn_q <= rgn;
        io_q  <= io_rdata;
      end
    end
  end

  // Read data source for the latched region
  always_comb begin
    rd_data = UNMAP_VAL;
    case (rgn_q)
      RGN_RAM, RGN_EXP: rd_data = ram_rdata;
      RGN_ROM:          rd_data = rom_rdata;
      RGN_VRAM:         rd_data = vram_rdata;
      RGN_IO:           rd_data = io_q;
      default:          rd_data = UNMAP_VAL;
    endcase
  end

  // CPU read data register, held until the next read completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout <= UNMAP_VAL;
    end else if (rd_pend) begin
      cpu_dout <= rd_data;
    end
  end

  // DMA state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DMA_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DMA next state and completion outputs; ACC retries while the CPU holds the ports
  always_comb begin
    state_nxt = state;
    dma_ack   = 1'b0;
    dma_dout  = 8'h00;
    case (state)
      DMA_IDLE: if (dma_req && !cpu_ce) state_nxt = DMA_ACC;
      DMA_ACC:  if (!cpu_ce) state_nxt = DMA_ACK;
      DMA_ACK: begin
        state_nxt = DMA_IDLE;
        dma_ack   = 1'b1;
        dma_dout  = dma_space ? rom_rdata : ram_rdata;
      end
      default:  state_nxt = DMA_IDLE;
    endcase
  end

  // Memory port ownership: CPU in its ce clk, otherwise DMA while in ACC.
  // ROM has no data port of its own; DMA ROM writes take their data from ram_wdata.
  always_comb begin
    ram_addr  = cpu_ram_addr;
    ram_wdata = cpu_din;
    ram_we    = 1'b0;
    rom_addr  = cpu_rom_addr;
    rom_we    = 1'b0;
    vram_we   = cpu_ce && cpu_we && (rgn == RGN_VRAM);
    io_cs     = cpu_ce && (rgn == RGN_IO);
    if (cpu_ce) begin
      ram_we = cpu_we && wr_ok && !ctrl_hit && ((rgn == RGN_RAM) || (rgn == RGN_EXP));
    end else if (state == DMA_ACC) begin
      ram_wdata = dma_din;
      if (dma_space) begin
        rom_addr = dma_addr[ROM_AW-1:0];
        rom_we   = dma_we;
      end else begin
        ram_addr = dma_addr;
        ram_we   = dma_we;
      end
    end
  end

endmodule

// File: tb/tb_pet_bus_mapper.sv
// Self-checking bench for pet_bus_mapper: directed map cases, randomized CPU/DMA traffic, reset abort.
// Latency: checks cpu_dout two edges after the ce cycle starts, dma_ack two clk after grant.
// Backpressure: DMA requests overlap CPU cycles to exercise port arbitration.
module tb_pet_bus_mapper;

  localparam int RAM_AW  = 17;
  localparam int VRAM_AW = 10;
  localparam int ROM_AW  = 15;

  localparam int K_RAM  = 0;
  localparam int K_VRAM = 1;
  localparam int K_ROM  = 2;
  localparam int K_IO   = 3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cpu_ce = 1'b0;
  logic [15:0]        cpu_addr = 16'h0000;
  logic               cpu_we = 1'b0;
  logic [7:0]         cpu_din = 8'h00;
  logic [7:0]         cpu_dout;
  logic [RAM_AW-1:0]  ram_addr;
  logic               ram_we;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata = 8'h00;
  logic [ROM_AW-1:0]  rom_addr;
  logic               rom_we;
  logic [7:0]         rom_rdata = 8'h00;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_we;
  logic [7:0]         vram_rdata = 8'h00;
  logic               io_cs;
  logic [7:0]         io_rdata;
  logic               dma_req = 1'b0;
  logic               dma_space = 1'b0;
  logic [RAM_AW-1:0]  dma_addr = '0;
  logic               dma_we = 1'b0;
  logic [7:0]         dma_din = 8'h00;
  logic [7:0]         dma_dout;
  logic               dma_ack;
  logic [7:0]         ctrl_q;

  int total = 0;
  int bad   = 0;

  // Device-side memories (driven only by DUT strobes) and reference copies (driven by the model)
  logic [7:0] ram_mem  [int];
  logic [7:0] rom_mem  [int];
  logic [7:0] vram_mem [int];
  logic [7:0] ref_ram  [int];
  logic [7:0] ref_rom  [int];
  logic [7:0] ref_vram [int];
  logic [7:0] ref_ctrl = 8'h00;
  logic [7:0] ref_dout = 8'h55;

  int cpu_pool [10] = '{'h0010, 'h7FF0, 'h8010, 'h8810, 'h9010, 'hA010, 'hC010, 'hE010, 'hE810, 'hF010};
  int dram_pool [5] = '{'h00010, 'h08010, 'h0C010, 'h10010, 'h14010};
  int drom_pool [2] = '{'h1010, 'h2010};

  pet_bus_mapper dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_ce     (cpu_ce),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .rom_addr   (rom_addr),
    .rom_we     (rom_we),
    .rom_rdata  (rom_rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_rdata (vram_rdata),
    .io_cs      (io_cs),
    .io_rdata   (io_rdata),
    .dma_req    (dma_req),
    .dma_space  (dma_space),
    .dma_addr   (dma_addr),
    .dma_we     (dma_we),
    .dma_din    (dma_din),
    .dma_dout   (dma_dout),
    .dma_ack    (dma_ack),
    .ctrl_q     (ctrl_q)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_init(input int a);
    if (a == 'h100) return 8'hA5;
    return 8'((a * 37) ^ (a >> 7) ^ 'h5A);
  endfunction

  function automatic logic [7:0] rom_init(input int a);
    return 8'((a * 53) ^ (a >> 6) ^ 'h3C);
  endfunction

  function automatic logic [7:0] vram_init(input int a);
    return 8'((a * 29) ^ 'h96);
  endfunction

  function automatic logic [7:0] ref_ram_rd(input int a);
    return ref_ram.exists(a) ? ref_ram[a] : ram_init(a);
  endfunction

  function automatic logic [7:0] ref_rom_rd(input int a);
    return ref_rom.exists(a) ? ref_rom[a] : rom_init(a);
  endfunction

  function automatic logic [7:0] ref_vram_rd(input int a);
    return ref_vram.exists(a) ? ref_vram[a] : vram_init(a);
  endfunction

  // Synchronous memories with one clk read latency, read-before-write
  always @(posedge clk) begin
    ram_rdata  <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : ram_init(int'(ram_addr));
    rom_rdata  <= rom_mem.exists(int'(rom_addr)) ? rom_mem[int'(rom_addr)] : rom_init(int'(rom_addr));
    vram_rdata <= vram_mem.exists(int'(vram_addr)) ? vram_mem[int'(vram_addr)] : vram_init(int'(vram_addr));
    if (ram_we)  ram_mem[int'(ram_addr)]   = ram_wdata;
    if (rom_we)  rom_mem[int'(rom_addr)]   = ram_wdata;
    if (vram_we) vram_mem[int'(vram_addr)] = cpu_din;
  end

  assign io_rdata = cpu_addr[7:0] ^ 8'hC3;

  // Memory map model written as address ranges and bank arithmetic
  function automatic void ref_map(input int a, input logic [7:0] c,
                                  output int kind, output int phys, output bit wp);
    int bank;
    wp   = 1'b0;
    phys = 0;
    kind = K_RAM;
    if (a < 'h8000) begin
      kind = K_RAM;
      phys = a;
    end else if (c[7] && c[5] && a < 'h9000) begin
      kind = K_VRAM;
      phys = a % (1 << VRAM_AW);
    end else if (c[7] && c[6] && a >= 'hE800 && a <= 'hEFFF) begin
      kind = K_IO;
    end else if (c[7]) begin
      kind = K_RAM;
      if (a < 'hC000) begin
        bank = c[0] ? 2 : 0;
        wp   = c[2];
      end else begin
        bank = c[1] ? 3 : 1;
        wp   = c[3];
      end
      phys = 'h8000 + bank * 'h4000 + (a % 'h4000);
    end else if (a < 'h9000) begin
      kind = K_VRAM;
      phys = a % (1 << VRAM_AW);
    end else if (a >= 'hE800 && a <= 'hEFFF) begin
      kind = K_IO;
    end else begin
      kind = K_ROM;
      phys = a - 'h8000;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU bus cycle: strobes checked in the ce clk, read data and ctrl two edges later
  task automatic cpu_cycle(input bit we, input int a, input logic [7:0] d);
    int  kind;
    int  phys;
    bit  wp;
    bit  ctl;
    ref_map(a, ref_ctrl, kind, phys, wp);
    ctl = we && (a == 'hFFF0);
    @(posedge clk); #1;
    cpu_ce   = 1'b1;
    cpu_we   = we;
    cpu_addr = 16'(a);
    cpu_din  = d;
    #2;
    chk("ram_we", 32'(ram_we), 32'(we && kind == K_RAM && !wp && !ctl));
    if (kind == K_RAM) chk("ram_addr", 32'(ram_addr), phys);
    chk("vram_we", 32'(vram_we), 32'(we && kind == K_VRAM));
    if (kind == K_VRAM) chk("vram_addr", 32'(vram_addr), phys);
    chk("io_cs", 32'(io_cs), 32'(kind == K_IO));
    chk("rom_we", 32'(rom_we), 0);
    if (we) begin
      if (ctl) ref_ctrl = d;
      else if (kind == K_RAM && !wp) ref_ram[phys] = d;
      else if (kind == K_VRAM) ref_vram[phys] = d;
    end else begin
      case (kind)
        K_RAM:   ref_dout = ref_ram_rd(phys);
        K_VRAM:  ref_dout = ref_vram_rd(phys);
        K_ROM:   ref_dout = ref_rom_rd(phys);
        default: ref_dout = 8'((a & 'hFF) ^ 'hC3);
      endcase
    end
    @(posedge clk); #1;
    cpu_ce = 1'b0;
    cpu_we = 1'b0;
    @(posedge clk); #1;
    chk("cpu_dout", 32'(cpu_dout), 32'(ref_dout));
    chk("ctrl_q", 32'(ctrl_q), 32'(ref_ctrl));
  endtask

  // One DMA transfer with no competing CPU traffic
  task automatic dma_xfer(input bit sp, input int a, input bit we, input logic [7:0] d);
    bit         got;
    int         lat;
    int         ra;
    logic [7:0] exp_rd;
    ra     = sp ? (a % (1 << ROM_AW)) : a;
    exp_rd = sp ? ref_rom_rd(ra) : ref_ram_rd(ra);
    @(posedge clk); #1;
    dma_req   = 1'b1;
    dma_space = sp;
    dma_addr  = RAM_AW'(a);
    dma_we    = we;
    dma_din   = d;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      #2;
      if (dma_ack) begin
        got = 1'b1;
        lat = i;
        if (!we) chk("dma_dout", 32'(dma_dout), 32'(exp_rd));
      end
      @(posedge clk); #1;
    end
    dma_req = 1'b0;
    dma_we  = 1'b0;
    chk("dma_ack_seen", 32'(got), 1);
    chk("dma_latency", lat, 2);
    if (we) begin
      if (sp) ref_rom[ra] = d;
      else    ref_ram[ra] = d;
    end
  endtask

  initial begin
    int  r;
    int  a;
    bit  sp;

    // Reset state
    #12;
    chk("rst_cpu_dout", 32'(cpu_dout), 32'h55);
    chk("rst_ctrl_q", 32'(ctrl_q), 0);
    chk("rst_dma_ack", 32'(dma_ack), 0);
    chk("rst_dma_dout", 32'(dma_dout), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Base RAM read
    cpu_cycle(1'b0, 'h0100, 8'h00);

    // Expansion enabled, $8000 bank 2
    cpu_cycle(1'b1, 'hFFF0, 8'h81);
    cpu_cycle(1'b1, 'h8123, 8'h3C);
    cpu_cycle(1'b0, 'h8123, 8'h00);

    // Write protect on the $C000 window, read bank 1
    cpu_cycle(1'b1, 'hFFF0, 8'h88);
    cpu_cycle(1'b1, 'hC010, 8'hF7);
    cpu_cycle(1'b0, 'hC010, 8'h00);

    // I/O and screen peek-through
    cpu_cycle(1'b1, 'hFFF0, 8'hE0);
    cpu_cycle(1'b0, 'hE810, 8'h00);
    cpu_cycle(1'b1, 'h8005, 8'h6B);
    cpu_cycle(1'b0, 'h8405, 8'h00);

    // Classic map: VRAM mirror, ROM, and a ROM write that must be dropped
    cpu_cycle(1'b1, 'hFFF0, 8'h00);
    cpu_cycle(1'b0, 'h8C05, 8'h00);
    cpu_cycle(1'b1, 'hB000, 8'h11);
    cpu_cycle(1'b0, 'hB000, 8'h00);

    // Randomized CPU and DMA traffic
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        cpu_cycle(1'b1, 'hFFF0, 8'($urandom));
      end else if (r <= 2) begin
        sp = 1'($urandom_range(0, 1));
        if (sp) a = drom_pool[$urandom_range(0, 1)] + int'($urandom_range(0, 3)) * 'h8000;
        else    a = dram_pool[$urandom_range(0, 4)];
        dma_xfer(sp, a, 1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        if ($urandom_range(0, 1) == 1) a = cpu_pool[$urandom_range(0, 9)];
        else                           a = int'($urandom_range(0, 'hFFFF));
        cpu_cycle(1'($urandom_range(0, 1)), a, 8'($urandom));
      end
    end

    // DMA request arriving with a CPU cycle: CPU first, DMA write one clk after grant
    cpu_cycle(1'b1, 'hFFF0, 8'h00);
    @(posedge clk); #1;
    cpu_ce    = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0200;
    dma_req   = 1'b1;
    dma_space = 1'b0;
    dma_addr  = 17'h00400;
    dma_we    = 1'b1;
    dma_din   = 8'h77;
    #2;
    chk("t5_cpu_addr", 32'(ram_addr), 'h200);
    chk("t5_cpu_ram_we", 32'(ram_we), 0);
    chk("t5_ack_early", 32'(dma_ack), 0);
    ref_dout = ref_ram_rd('h200);
    @(posedge clk); #1;
    cpu_ce = 1'b0;
    #2;
    chk("t5_grant_we", 32'(ram_we), 0);
    @(posedge clk); #3;
    chk("t5_dma_we", 32'(ram_we), 1);
    chk("t5_dma_addr", 32'(ram_addr), 'h400);
    chk("t5_dma_wdata", 32'(ram_wdata), 32'h77);
    chk("t5_cpu_dout", 32'(cpu_dout), 32'(ref_dout));
    @(posedge clk); #3;
    chk("t5_ack", 32'(dma_ack), 1);
    @(posedge clk); #1;
    dma_req = 1'b0;
    dma_we  = 1'b0;
    ref_ram['h400] = 8'h77;
    cpu_cycle(1'b0, 'h0400, 8'h00);

    // Reset asserted while a DMA write sits in ACC
    cpu_cycle(1'b1, 'hFFF0, 8'h8C);
    cpu_cycle(1'b0, 'h0100, 8'h00);
    @(posedge clk); #1;
    dma_req   = 1'b1;
    dma_space = 1'b0;
    dma_addr  = 17'h00500;
    dma_we    = 1'b1;
    dma_din   = 8'hEE;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_ctrl_q", 32'(ctrl_q), 0);
    chk("t6_cpu_dout", 32'(cpu_dout), 32'h55);
    chk("t6_dma_ack", 32'(dma_ack), 0);
    chk("t6_ram_we", 32'(ram_we), 0);
    ref_ctrl = 8'h00;
    ref_dout = 8'h55;
    dma_req  = 1'b0;
    dma_we   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6_ack_hold", 32'(dma_ack), 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6_ack_after", 32'(dma_ack), 0);
    end
    cpu_cycle(1'b0, 'h0100, 8'h00);
    cpu_cycle(1'b0, 'hC010, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
